// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives an SRAM-like instruction bus with at
// most one fetch in flight, holds the IF->ID output register, applies branch
// redirects after the delay-slot fetch and flush redirects immediately.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        id_allow_in,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel,
  output logic [31:0] if_badaddr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_CANCEL, S_EXC} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        br_pend_q;
  logic [31:0] br_tgt_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;
  logic        if_adel_q;
  logic [31:0] if_badaddr_q;

  logic        slot_free;
  logic        pc_aligned;
  logic        req_acc;
  logic        fetch_done;
  logic [31:0] pc_d;

  // Output slot can take a new entry when empty or being drained by ID.
  assign slot_free  = !if_valid_q || id_allow_in;
  assign pc_aligned = (pc_q[1:0] == 2'b00);
  // Request is gated by resetn so nothing goes out during the reset cycle.
  assign inst_req   = resetn && (state_q == S_REQ) && slot_free && pc_aligned;
  assign inst_addr  = pc_q;
  assign req_acc    = inst_req && inst_addr_ok;
  assign fetch_done = (state_q == S_WAIT) && inst_data_ok && !flush;
  // A branch seen in the same cycle as data_ok is registered too late for
  // that completion, so it redirects after the following (delay-slot) fetch.
  assign pc_d       = br_pend_q ? br_tgt_q : pc_q + 32'd4;

  assign if_valid   = if_valid_q;
  assign if_pc      = if_pc_q;
  assign if_inst    = if_inst_q;
  assign if_adel    = if_adel_q;
  assign if_badaddr = if_badaddr_q;

  // Pending branch redirect: latest br_valid wins, flush discards it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      br_pend_q <= 1'b0;
      br_tgt_q  <= 32'd0;
    end else if (flush) begin
      br_pend_q <= 1'b0;
    end else if (br_valid) begin
      br_pend_q <= 1'b1;
      br_tgt_q  <= br_target;
    end else if (fetch_done) begin
      br_pend_q <= 1'b0;
    end
  end

  // Fetch FSM with PC and the registered IF output slot.
  // Data_ok is only consumed in WAIT, which is reachable only through a
  // request accepted after reset, so a stale pre-reset response is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'd0;
      if_inst_q    <= 32'd0;
      if_adel_q    <= 1'b0;
      if_badaddr_q <= 32'd0;
    end else begin
      if (if_valid_q && id_allow_in) if_valid_q <= 1'b0;
      if (flush) begin
        if_valid_q <= 1'b0;
        pc_q       <= flush_pc;
        case (state_q)
          S_REQ:    state_q <= req_acc ? S_CANCEL : S_REQ;
          S_WAIT:   state_q <= inst_data_ok ? S_REQ : S_CANCEL;
          S_CANCEL: state_q <= inst_data_ok ? S_REQ : S_CANCEL;
          default:  state_q <= S_REQ;
        endcase
      end else begin
        case (state_q)
          S_REQ: begin
            if (slot_free && !pc_aligned) begin
              if_valid_q   <= 1'b1;
              if_pc_q      <= pc_q;
              if_inst_q    <= 32'd0;
              if_adel_q    <= 1'b1;
              if_badaddr_q <= pc_q;
              state_q      <= S_EXC;
            end else if (req_acc) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (inst_data_ok) begin
              if_valid_q   <= 1'b1;
              if_pc_q      <= pc_q;
              if_inst_q    <= inst_rdata;
              if_adel_q    <= 1'b0;
              if_badaddr_q <= 32'd0;
              pc_q         <= pc_d;
              state_q      <= S_REQ;
            end
          end
          S_CANCEL: begin
            if (inst_data_ok) state_q <= S_REQ;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        id_allow_in;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic [31:0] if_badaddr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(32'hBFC00000)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .flush_pc(flush_pc),
    .br_valid(br_valid), .br_target(br_target), .id_allow_in(id_allow_in),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_adel(if_adel), .if_badaddr(if_badaddr)
  );

  // Count one comparison and report it if it misses.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // One full fetch with 1-cycle addr_ok/data_ok latency, starting in REQ.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input logic br, input logic [31:0] bt);
    chk("req", 32'(inst_req), 32'd1);
    chk("addr", inst_addr, a);
    inst_addr_ok = 1'b1;
    nxt();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = d;
    br_valid     = br;
    br_target    = bt;
    #1 chk("req_wait", 32'(inst_req), 32'd0);
    nxt();
    inst_data_ok = 1'b0;
    br_valid     = 1'b0;
    #1;
    chk("valid", 32'(if_valid), 32'd1);
    chk("pc", if_pc, a);
    chk("inst", if_inst, d);
    chk("adel", 32'(if_adel), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; flush_pc = 32'd0; br_valid = 1'b0;
    br_target = 32'd0; id_allow_in = 1'b1; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = 32'd0;

    // reset state
    nxt(); nxt(); #1;
    chk("rst_req", 32'(inst_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_adel", 32'(if_adel), 32'd0);
    chk("rst_bad", if_badaddr, 32'd0);
    resetn = 1'b1; #1;

    // sequential fetch; branch coincident with data_ok of 0x04 lands after 0x08
    fetch(32'hBFC00000, 32'h11111111, 1'b0, 32'd0);
    fetch(32'hBFC00004, 32'h22222222, 1'b1, 32'hBFC00100);
    fetch(32'hBFC00008, 32'h33333333, 1'b0, 32'd0);
    fetch(32'hBFC00100, 32'h44444444, 1'b0, 32'd0);

    // flush while WAIT, late data_ok discarded
    chk("f1_addr", inst_addr, 32'hBFC00104);
    inst_addr_ok = 1'b1;
    nxt(); inst_addr_ok = 1'b0; flush = 1'b1; flush_pc = 32'hBFC00380; #1;
    chk("f1_req0", 32'(inst_req), 32'd0);
    nxt(); flush = 1'b0; #1;
    chk("f1_req1", 32'(inst_req), 32'd0);
    chk("f1_valid1", 32'(if_valid), 32'd0);
    nxt(); #1 chk("f1_req2", 32'(inst_req), 32'd0);
    nxt(); inst_data_ok = 1'b1; inst_rdata = 32'h12345678; #1;
    chk("f1_req3", 32'(inst_req), 32'd0);
    nxt(); inst_data_ok = 1'b0; #1;
    chk("f1_valid", 32'(if_valid), 32'd0);
    fetch(32'hBFC00380, 32'h55555555, 1'b0, 32'd0);

    // flush coincident with data_ok; branch coincident with flush ignored
    chk("f2_addr", inst_addr, 32'hBFC00384);
    inst_addr_ok = 1'b1;
    nxt(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF;
    flush = 1'b1; flush_pc = 32'hBFC00500; br_valid = 1'b1; br_target = 32'hBFC00700;
    nxt(); inst_data_ok = 1'b0; flush = 1'b0; br_valid = 1'b0; #1;
    chk("f2_valid", 32'(if_valid), 32'd0);
    fetch(32'hBFC00500, 32'h66666666, 1'b0, 32'd0);
    chk("f2_nobr", inst_addr, 32'hBFC00504);

    // misaligned flush target -> AdEL, stuck in EXC until flush
    flush = 1'b1; flush_pc = 32'hBFC00382;
    nxt(); flush = 1'b0; #1;
    chk("ex_req0", 32'(inst_req), 32'd0);
    chk("ex_valid0", 32'(if_valid), 32'd0);
    nxt(); #1;
    chk("ex_valid", 32'(if_valid), 32'd1);
    chk("ex_adel", 32'(if_adel), 32'd1);
    chk("ex_bad", if_badaddr, 32'hBFC00382);
    chk("ex_pc", if_pc, 32'hBFC00382);
    chk("ex_inst", if_inst, 32'd0);
    chk("ex_req1", 32'(inst_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("ex_hold_req", 32'(inst_req), 32'd0);
      chk("ex_hold_valid", 32'(if_valid), 32'd0);
    end
    flush = 1'b1; flush_pc = 32'hBFC00380;
    nxt(); flush = 1'b0; #1;
    chk("ex_out_req", 32'(inst_req), 32'd1);
    chk("ex_out_addr", inst_addr, 32'hBFC00380);

    // ID stall holds the output and blocks requests
    inst_addr_ok = 1'b1;
    nxt(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h77777777;
    nxt(); inst_data_ok = 1'b0; id_allow_in = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("st_req", 32'(inst_req), 32'd0);
      chk("st_valid", 32'(if_valid), 32'd1);
      chk("st_pc", if_pc, 32'hBFC00380);
      chk("st_inst", if_inst, 32'h77777777);
      nxt(); #1;
    end
    id_allow_in = 1'b1; #1;
    chk("st_still", 32'(if_valid), 32'd1);
    nxt(); #1;
    chk("st_drain", 32'(if_valid), 32'd0);
    chk("st_req_on", 32'(inst_req), 32'd1);
    chk("st_addr", inst_addr, 32'hBFC00384);

    // reset mid-fetch; stale data_ok after release is ignored
    inst_addr_ok = 1'b1;
    nxt(); inst_addr_ok = 1'b0; resetn = 1'b0; #1;
    chk("mr_req", 32'(inst_req), 32'd0);
    nxt(); resetn = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hBAD0BAD0; #1;
    chk("mr_addr", inst_addr, 32'hBFC00000);
    nxt(); inst_data_ok = 1'b0; #1;
    chk("mr_valid", 32'(if_valid), 32'd0);
    fetch(32'hBFC00000, 32'h88888888, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
